// File: rtl/interface_tx_bridge_pkg.sv
// Shared definitions for the bus-to-UART transmit bridge: default parameters
// and the transmitter state encoding.
package interface_tx_bridge_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } tx_state_e;

endpackage

// File: rtl/interface_tx_bridge_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty flags; full is judged
// before any same-cycle pop, so a write into a full FIFO is always refused.
module sync_fifo
    import interface_tx_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        ptr_inc = (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;

    // Occupancy after this cycle's accepted push/pop
    always_comb begin
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
            empty_r <= (count_next_s == {CW{1'b0}});
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/interface_tx_bridge.sv
// Buffers bytes written by a bus slave and serialises them as 8N1 UART
// frames, LSB first, with one idle cycle between back-to-back frames.
module interface_tx_bridge
    import interface_tx_bridge_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic                  full,
    output logic                  overflow,
    output logic [CW-1:0]         fifo_count,
    output logic                  tx_busy,
    output logic                  uart_tx
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state_r;
    tx_state_e             next_state_s;
    logic [PW-1:0]         clk_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_next_s;
    logic [DATA_WIDTH-1:0] fifo_dout_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  bit_end_s;
    logic                  last_bit_s;
    logic                  pop_s;
    logic                  uart_tx_next_s;
    logic                  tx_busy_next_s;
    logic                  uart_tx_r;
    logic                  tx_busy_r;
    logic                  wr_ack_r;
    logic                  overflow_r;

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (wr_en),
        .pop  (pop_s),
        .din  (wr_data),
        .dout (fifo_dout_s),
        .count(fifo_count),
        .full (fifo_full_s),
        .empty(fifo_empty_s)
    );

    assign bit_end_s  = (clk_cnt_r == PW'(CLKS_PER_BIT - 1));
    assign last_bit_s = (bit_cnt_r == BW'(DATA_WIDTH - 1));
    assign pop_s      = (state_r == TX_IDLE) && !fifo_empty_s;

    // Transmitter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            TX_IDLE:  if (pop_s) next_state_s = TX_START; else next_state_s = TX_IDLE;
            TX_START: if (bit_end_s) next_state_s = TX_DATA; else next_state_s = TX_START;
            TX_DATA:  if (bit_end_s && last_bit_s) next_state_s = TX_STOP; else next_state_s = TX_DATA;
            TX_STOP:  if (bit_end_s) next_state_s = TX_IDLE; else next_state_s = TX_STOP;
            default:  next_state_s = TX_IDLE;
        endcase
    end

    // Next line level is derived from the next state so uart_tx can be registered
    always_comb begin
        shift_next_s = shift_r;
        if (pop_s) begin
            shift_next_s = fifo_dout_s;
        end else if ((state_r == TX_DATA) && bit_end_s) begin
            shift_next_s = shift_r >> 1;
        end else begin
            shift_next_s = shift_r;
        end
        case (next_state_s)
            TX_IDLE:  uart_tx_next_s = 1'b1;
            TX_START: uart_tx_next_s = 1'b0;
            TX_DATA:  uart_tx_next_s = shift_next_s[0];
            TX_STOP:  uart_tx_next_s = 1'b1;
            default:  uart_tx_next_s = 1'b1;
        endcase
        tx_busy_next_s = (next_state_s != TX_IDLE);
    end

    // Bit timing, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt_r  <= {PW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            shift_r    <= {DATA_WIDTH{1'b0}};
            uart_tx_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
            wr_ack_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            shift_r    <= shift_next_s;
            uart_tx_r  <= uart_tx_next_s;
            tx_busy_r  <= tx_busy_next_s;
            wr_ack_r   <= wr_en && !fifo_full_s;
            overflow_r <= overflow_r || (wr_en && fifo_full_s);
            if ((state_r == TX_IDLE) || bit_end_s) begin
                clk_cnt_r <= {PW{1'b0}};
            end else begin
                clk_cnt_r <= clk_cnt_r + PW'(1);
            end
            if (state_r != TX_DATA) begin
                bit_cnt_r <= {BW{1'b0}};
            end else if (bit_end_s) begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign uart_tx  = uart_tx_r;
    assign tx_busy  = tx_busy_r;
    assign wr_ack   = wr_ack_r;
    assign overflow = overflow_r;
    assign full     = fifo_full_s;

endmodule

// File: tb/tb_interface_tx_bridge.sv
// Scoreboard bench: writes queue expected bytes/ack times; independent monitors
// decode UART frames and wr_ack pulses and compare against those queues.
module tb_interface_tx_bridge;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       full;
    logic       overflow;
    logic [2:0] fifo_count;
    logic       tx_busy;
    logic       uart_tx;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         wr_cyc = 0;
    logic [7:0] exp_q[$];
    int         ack_q[$];
    int         start_q[$];
    logic       mon_busy = 1'b0;
    logic       samp [FRAME];

    interface_tx_bridge #(
        .DATA_WIDTH  (8),
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .full      (full),
        .overflow  (overflow),
        .fifo_count(fifo_count),
        .tx_busy   (tx_busy),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // Called at a negedge; drives one write strobe for a single cycle
    task automatic write_byte(input logic [7:0] d, input bit exp_ack, input bit exp_frame);
        wr_en   = 1'b1;
        wr_data = d;
        wr_cyc  = cyc;
        if (exp_ack)   ack_q.push_back(cyc + 1);
        if (exp_frame) exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (!(exp_q.size() == 0 && !mon_busy && tx_busy === 1'b0 && fifo_count === 3'd0)
               && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) timeout(name);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int k = 0;
        while (tx_busy !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) timeout(name);
    endtask

    // Ack monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && wr_ack === 1'b1) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: wr_ack high at cycle %0d, none expected", cyc);
                end else begin
                    check("ack_cycle", cyc, ack_q.pop_front());
                end
            end
        end
    end

    // UART frame monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                logic       aborted;
                logic       shape_ok;
                logic [7:0] rx;
                mon_busy = 1'b1;
                aborted  = 1'b0;
                start_q.push_back(cyc);
                samp[0] = uart_tx;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[k] = uart_tx;
                end
                if (!aborted) begin
                    shape_ok = (samp[0] == 1'b0) && (samp[9*CPB] == 1'b1);
                    for (int b = 0; b < 10; b++)
                        for (int j = 0; j < CPB; j++)
                            if (samp[b*CPB+j] !== samp[b*CPB]) shape_ok = 1'b0;
                    for (int i = 0; i < 8; i++) rx[i] = samp[(i+1)*CPB];
                    check("frame_shape", {31'd0, shape_ok}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got byte %0h, none expected", rx);
                    end else begin
                        check("frame_data", {24'd0, rx}, {24'd0, exp_q.pop_front()});
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", fifo_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte A5: latency, bit pattern and return to idle
        write_byte(8'hA5, 1'b1, 1'b1);
        c0 = wr_cyc;
        wait_idle(400, "t1_idle");
        check("t1_frames", start_q.size(), 1);
        if (start_q.size() > 0) check("t1_start_latency", start_q[0], c0 + 2);
        check("t1_tx_busy", tx_busy, 0);
        check("t1_uart_idle", uart_tx, 1);

        // Overflow while transmitting, then full write rejected during an IDLE pop
        write_byte(8'h10, 1'b1, 1'b1);
        wait_busy(1'b1, 10, "t2_busy");
        for (int i = 1; i <= 5; i++) write_byte(8'(i), i <= 4, i <= 4);
        check("t2_full", full, 1);
        check("t2_overflow", overflow, 1);
        check("t2_count_full", fifo_count, 4);
        wait_busy(1'b0, 400, "t2_idle_pop");
        write_byte(8'hEE, 1'b0, 1'b0);
        check("t2_count_after_pop", fifo_count, 3);
        check("t2_full_after_pop", full, 0);
        wait_idle(1200, "t2_drain");
        check("t2_overflow_sticky", overflow, 1);

        // Push and pop in the same cycle at count 2, across pointer wrap
        write_byte(8'h20, 1'b1, 1'b1);
        write_byte(8'h21, 1'b1, 1'b1);
        write_byte(8'h22, 1'b1, 1'b1);
        check("t3_count2", fifo_count, 2);
        wait_busy(1'b0, 400, "t3_idle_pop");
        write_byte(8'h23, 1'b1, 1'b1);
        check("t3_count_push_pop", fifo_count, 2);
        wait_idle(800, "t3_drain");

        // Back-to-back frames 00, FF: 161 cycles pop to pop
        n = start_q.size();
        write_byte(8'h00, 1'b1, 1'b1);
        write_byte(8'hFF, 1'b1, 1'b1);
        wait_idle(600, "t4_drain");
        check("t4_frames", start_q.size(), n + 2);
        if (start_q.size() >= n + 2) check("t4_spacing", start_q[n+1] - start_q[n], 161);

        // Reset during the third data bit
        write_byte(8'h3B, 1'b1, 1'b0);
        c0 = wr_cyc;
        write_byte(8'h55, 1'b1, 1'b0);
        while (cyc < c0 + 52) @(negedge clk);
        check("t5_pre_rst_line", uart_tx, 0);
        rst = 1'b1;
        #1;
        check("t5_rst_uart_tx", uart_tx, 1);
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_busy", tx_busy, 0);
        check("t5_rst_overflow", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = start_q.size();
        repeat (300) @(negedge clk);
        check("t5_no_frame", start_q.size(), n);
        check("t5_line_idle", uart_tx, 1);
        check("t5_count", fifo_count, 0);

        check("end_frames_pending", exp_q.size(), 0);
        check("end_acks_pending", ack_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
